tx_shifter: RTL and testbench

TX_SHIFTER -- requirements
Module: tx_shifter

---
 rtl/tx_shifter.sv | 129 ++++++++++++
 tb/tb_tx_shifter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_shifter.sv
// tx_shifter: 8N1 / 8E1 / 8O1 UART transmit serializer.
// Registered line output, one-cycle done pulse at frame end.
module tx_shifter #(
  parameter int unsigned BAUD_DIV   = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       tClk,
  input  logic       tRst,
  input  logic       tLoad,
  input  logic [7:0] tdataIn,
  output logic       tRdy,
  output logic       tTx,
  output logic       tDone,
  output logic       tBusy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt_q == LAST);

  // Next-state, bit timing and next line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (tLoad) begin
          state_d = START;
          sh_d    = tdataIn;
          par_d   = (^tdataIn) ^ PARITY_ODD;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, counters, shift register and line register.
  always_ff @(posedge tClk or negedge tRst) begin
    if (!tRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tRdy  = (state_q == IDLE);
  assign tBusy = ~tRdy;
  assign tDone = (state_q == STOP) && bit_end;
  assign tTx   = tx_q;

endmodule

// File: tb/tb_tx_shifter.sv
// tb_tx_shifter: three tx_shifter configs checked against
// a frame-level bit model and a UART receiver scoreboard.
module tb_tx_shifter;

  logic       tClk = 1'b0;
  logic       tRst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din  = 8'h00;
  logic [1:0] sel  = 2'd0;

  logic ldA, ldB, ldC;
  logic rdyA, txA, doneA, busyA;
  logic rdyB, txB, doneB, busyB;
  logic rdyC, txC, doneC, busyC;
  logic rdy, tx, done, busy;

  int ntests = 0;
  int nfail  = 0;

  bit         rx_en = 1'b0;
  int         nrx   = 0;
  logic [7:0] expq[$];

  always #5 tClk = ~tClk;

  assign ldA = load && (sel == 2'd0);
  assign ldB = load && (sel == 2'd1);
  assign ldC = load && (sel == 2'd2);

  assign rdy  = (sel == 2'd0) ? rdyA  : (sel == 2'd1) ? rdyB  : rdyC;
  assign tx   = (sel == 2'd0) ? txA   : (sel == 2'd1) ? txB   : txC;
  assign done = (sel == 2'd0) ? doneA : (sel == 2'd1) ? doneB : doneC;
  assign busy = (sel == 2'd0) ? busyA : (sel == 2'd1) ? busyB : busyC;

  tx_shifter #(
    .BAUD_DIV(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) dA (
    .tClk(tClk), .tRst(tRst), .tLoad(ldA), .tdataIn(din),
    .tRdy(rdyA), .tTx(txA), .tDone(doneA), .tBusy(busyA)
  );

  tx_shifter #(
    .BAUD_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dB (
    .tClk(tClk), .tRst(tRst), .tLoad(ldB), .tdataIn(din),
    .tRdy(rdyB), .tTx(txB), .tDone(doneB), .tBusy(busyB)
  );

  tx_shifter #(
    .BAUD_DIV(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
  ) dC (
    .tClk(tClk), .tRst(tRst), .tLoad(ldC), .tdataIn(din),
    .tRdy(rdyC), .tTx(txC), .tDone(doneC), .tBusy(busyC)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit par_of(input logic [7:0] d,
                                input bit odd);
    return (($countones(d) % 2) == 1) ^ odd;
  endfunction

  // Line level of frame slot k: start, 8 data LSB first,
  // optional parity, stop.
  function automatic bit exp_bit(input logic [7:0] d,
                                 input bit pen,
                                 input bit podd,
                                 input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (pen && k == 9) return par_of(d, podd);
    return 1'b1;
  endfunction

  task automatic wait_rdy(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge tClk);
      ok = rdy;
    end
    chk(tag, ok, 1);
  endtask

  // Called at a negedge with the selected DUT idle.
  task automatic frame_check(input string tag,
                             input logic [7:0] d,
                             input int b,
                             input bit pen,
                             input bit podd,
                             input bit hold,
                             input logic [7:0] nd);
    int n;
    n = (pen ? 11 : 10) * b;
    din  = d;
    load = 1'b1;
    @(posedge tClk);
    #1;
    if (hold) din = nd;
    else load = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge tClk);
      chk({tag, "_tx"}, tx, exp_bit(d, pen, podd, c / b));
      chk({tag, "_done"}, done, (c == n - 1));
      chk({tag, "_rdy"}, rdy, 0);
      chk({tag, "_busy"}, busy, 1);
    end
    @(negedge tClk);
    chk({tag, "_rdy_end"}, rdy, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_tx_end"}, tx, 1);
  endtask

  // UART receiver on dC (BAUD_DIV=2, odd parity).
  initial begin
    int         cnt;
    int         idle_n;
    int         k;
    bit         act;
    logic [7:0] rb;
    logic [7:0] e;
    logic       rp;
    cnt    = 0;
    idle_n = 0;
    act    = 1'b0;
    rb     = '0;
    rp     = 1'b0;
    forever begin
      @(negedge tClk);
      if (rx_en) begin
        if (!act) begin
          if (txC == 1'b0) begin
            if (nrx > 0) chk("rx_gap", idle_n, 1);
            act    = 1'b1;
            cnt    = 0;
            idle_n = 0;
          end else begin
            idle_n++;
          end
        end else begin
          cnt++;
          if ((cnt % 2) == 1) begin
            k = cnt / 2;
            if (k == 0) begin
              chk("rx_start", txC, 0);
            end else if (k <= 8) begin
              rb[k-1] = txC;
            end else if (k == 9) begin
              rp = txC;
            end else begin
              chk("rx_stop", txC, 1);
              if (expq.size() == 0) begin
                chk("rx_extra", 1, 0);
              end else begin
                e = expq.pop_front();
                chk("rx_byte", rb, e);
                chk("rx_parity", rp, par_of(e, 1'b1));
              end
              nrx++;
              act = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] rbyte;
    repeat (3) @(negedge tClk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_rdy", rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    @(negedge tClk);
    tRst = 1'b1;

    sel = 2'd0;
    wait_rdy("rdy_a5");
    frame_check("a5", 8'hA5, 4, 1'b0, 1'b0, 1'b0, 8'h00);

    sel = 2'd1;
    wait_rdy("rdy_pe");
    frame_check("par_even", 8'h07, 4, 1'b1, 1'b0, 1'b0, 8'h00);

    sel = 2'd2;
    wait_rdy("rdy_po");
    frame_check("par_odd", 8'h07, 2, 1'b1, 1'b1, 1'b0, 8'h00);

    sel = 2'd0;
    wait_rdy("rdy_hold");
    frame_check("hold_ff", 8'hFF, 4, 1'b0, 1'b0, 1'b1, 8'h3C);
    frame_check("hold_3c", 8'h3C, 4, 1'b0, 1'b0, 1'b0, 8'h00);

    wait_rdy("rdy_abort");
    din  = 8'hF0;
    load = 1'b1;
    @(posedge tClk);
    #1;
    load = 1'b0;
    repeat (18) @(negedge tClk);
    chk("pre_rst_tx", tx, 0);
    tRst = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_rdy", rdy, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) begin
      @(negedge tClk);
      chk("abort_done_hold", done, 0);
      chk("abort_tx_hold", tx, 1);
    end
    tRst = 1'b1;
    frame_check("after_rst", 8'h55, 4, 1'b0, 1'b0, 1'b0, 8'h00);

    sel   = 2'd2;
    rx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rbyte = 8'($urandom);
      expq.push_back(rbyte);
      wait_rdy("rdy_rand");
      din  = rbyte;
      load = 1'b1;
      @(posedge tClk);
      #1;
    end
    load = 1'b0;
    for (int t = 0; t < 2000 && nrx < 16; t++) @(negedge tClk);
    chk("rx_count", nrx, 16);
    rx_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
